avl_dp_ram: RTL and testbench

Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2), configurable data width, depth and read latency. It also provides pipelined readdatavalid signalling, same-address write collision resolution, and an optional zero-fill engine that runs after reset. It sits on the HPS-to-FPGA interconnect as a shared buffer between the HPS bridge (s1) and fabric masters (s2).

---
 rtl/avl_dp_ram_if.sv | 28 ++
 rtl/avl_dp_ram.sv | 149 ++++++++++++++
 tb/tb_avl_dp_ram.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avl_dp_ram_if.sv
// Avalon-MM slave port bundle for avl_dp_ram.
// One instance per port; master drives commands, slave returns data.
interface avl_dp_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write,
        output byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write,
        input  byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avl_dp_ram.sv
// Dual-port Avalon-MM RAM with byte enables, pipelined read return
// and an optional zero-fill engine that runs after reset.
module avl_dp_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clken,
    avl_dp_ram_if.slave   s1,
    avl_dp_ram_if.slave   s2,
    output logic          busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam int L     = READ_LATENCY;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (L < 1 || L > 2) begin : g_bad_lat
        $error("READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  clr_we;
    logic                  stall;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc1;
    logic                  acc2;
    logic                  wr1;
    logic                  wr2;
    logic                  rd1;
    logic                  rd2;

    logic [L-1:0]          v1;
    logic [L-1:0]          v2;
    logic [DATA_WIDTH-1:0] d1 [L];
    logic [DATA_WIDTH-1:0] d2 [L];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        unique case (state)
            CLEAR: begin
                if (clken) begin
                    clr_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == '1) begin
                        state_nxt = READY;
                    end
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

    assign busy  = (state == CLEAR);
    assign stall = busy | ~clken;

    assign s1.waitrequest = stall;
    assign s2.waitrequest = stall;

    assign acc1 = s1.chipselect & (s1.read | s1.write) & ~stall;
    assign acc2 = s2.chipselect & (s2.read | s2.write) & ~stall;
    assign wr1  = acc1 & s1.write;
    assign wr2  = acc2 & s2.write;
    assign rd1  = acc1 & s1.read & ~s1.write;
    assign rd2  = acc2 & s2.read & ~s2.write;

    // s1 lanes are written last so they win on a shared address
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (wr2 && s2.byteenable[b]) begin
                mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            end
            if (wr1 && s1.byteenable[b]) begin
                mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
            end
        end
    end

    // data stages only load on a valid so readdata holds between reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= '0;
            v2 <= '0;
            for (int i = 0; i < L; i++) begin
                d1[i] <= '0;
                d2[i] <= '0;
            end
        end else if (clken) begin
            v1[0] <= rd1;
            v2[0] <= rd2;
            if (rd1) begin
                d1[0] <= mem[s1.address];
            end
            if (rd2) begin
                d2[0] <= mem[s2.address];
            end
            for (int i = 1; i < L; i++) begin
                v1[i] <= v1[i-1];
                v2[i] <= v2[i-1];
                if (v1[i-1]) begin
                    d1[i] <= d1[i-1];
                end
                if (v2[i-1]) begin
                    d2[i] <= d2[i-1];
                end
            end
        end
    end

    assign s1.readdatavalid = v1[L-1] & clken;
    assign s2.readdatavalid = v2[L-1] & clken;
    assign s1.readdata      = d1[L-1];
    assign s2.readdata      = d2[L-1];
endmodule

// File: tb/tb_avl_dp_ram.sv
// Bench for avl_dp_ram: latency-1 and latency-2 instances driven in
// lockstep, checked against a word-array model and expected-read queues.
module tb_avl_dp_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clken;
    logic busy_a;
    logic busy_b;

    avl_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a1 ();
    avl_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a2 ();
    avl_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b1 ();
    avl_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b2 ();

    avl_dp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_l1 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1(a1), .s2(a2), .busy(busy_a)
    );

    avl_dp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_l2 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1(b1), .s2(b2), .busy(busy_b)
    );

    logic [9:0]  p_addr [2];
    logic        p_cs   [2];
    logic        p_rd   [2];
    logic        p_wr   [2];
    logic [3:0]  p_be   [2];
    logic [31:0] p_wd   [2];
    logic        p_ovr  [2];
    logic [31:0] p_exp  [2];

    assign a1.address = p_addr[0]; assign b1.address = p_addr[0];
    assign a1.chipselect = p_cs[0]; assign b1.chipselect = p_cs[0];
    assign a1.read = p_rd[0]; assign b1.read = p_rd[0];
    assign a1.write = p_wr[0]; assign b1.write = p_wr[0];
    assign a1.byteenable = p_be[0]; assign b1.byteenable = p_be[0];
    assign a1.writedata = p_wd[0]; assign b1.writedata = p_wd[0];
    assign a2.address = p_addr[1]; assign b2.address = p_addr[1];
    assign a2.chipselect = p_cs[1]; assign b2.chipselect = p_cs[1];
    assign a2.read = p_rd[1]; assign b2.read = p_rd[1];
    assign a2.write = p_wr[1]; assign b2.write = p_wr[1];
    assign a2.byteenable = p_be[1]; assign b2.byteenable = p_be[1];
    assign a2.writedata = p_wd[1]; assign b2.writedata = p_wd[1];

    // index = instance*2 + port
    logic        vld [4];
    logic [31:0] dat [4];
    logic        wt  [4];
    assign vld[0] = a1.readdatavalid; assign dat[0] = a1.readdata;
    assign vld[1] = a2.readdatavalid; assign dat[1] = a2.readdata;
    assign vld[2] = b1.readdatavalid; assign dat[2] = b1.readdata;
    assign vld[3] = b2.readdatavalid; assign dat[3] = b2.readdata;
    assign wt[0] = a1.waitrequest; assign wt[1] = a2.waitrequest;
    assign wt[2] = b1.waitrequest; assign wt[3] = b2.waitrequest;

    typedef struct {
        logic [31:0] d;
        int          t;
    } exp_t;

    exp_t        q [4][$];
    exp_t        e;
    int          lat [4] = '{1, 1, 2, 2};
    logic [31:0] model [1024];
    int          ecnt = 0;
    int          vectors = 0;
    int          errors = 0;

    // counts enabled edges; a read issued at count k returns at k+latency
    always @(posedge clk) begin
        if (clken === 1'b1) ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (clken === 1'b0) begin
                    vectors++;
                    assert (vld[i] === 1'b0 && wt[i] === 1'b1) else begin
                        errors++;
                        $error("FAIL stall[%0d] observed vld=%b wait=%b expected vld=0 wait=1",
                               i, vld[i], wt[i]);
                    end
                end else if (vld[i] === 1'b1) begin
                    vectors++;
                    if (q[i].size() == 0) begin
                        errors++;
                        $error("FAIL spurious_valid[%0d] observed data=%h expected no pulse",
                               i, dat[i]);
                    end else begin
                        e = q[i].pop_front();
                        assert (dat[i] === e.d && ecnt === e.t) else begin
                            errors++;
                            $error("FAIL read[%0d] observed %h@%0d expected %h@%0d",
                                   i, dat[i], ecnt, e.d, e.t);
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            p_addr[p] = '0; p_cs[p] = 1'b0; p_rd[p] = 1'b0;
            p_wr[p] = 1'b0; p_be[p] = '0; p_wd[p] = '0;
            p_ovr[p] = 1'b0; p_exp[p] = '0;
        end
    endtask

    task automatic set_wr(input int p, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        p_addr[p] = a; p_cs[p] = 1'b1; p_wr[p] = 1'b1;
        p_rd[p] = 1'b0; p_wd[p] = d; p_be[p] = be;
    endtask

    task automatic set_rd(input int p, input logic [9:0] a,
                          input logic [31:0] x);
        p_addr[p] = a; p_cs[p] = 1'b1; p_rd[p] = 1'b1;
        p_wr[p] = 1'b0; p_ovr[p] = 1'b1; p_exp[p] = x;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // one bus cycle: reads see old words, then s2 and s1 writes land,
    // s1 last so shared lanes end up with s1 data
    task automatic step();
        logic [31:0] old [2];
        for (int p = 0; p < 2; p++) old[p] = model[p_addr[p]];
        if (clken) begin
            for (int p = 0; p < 2; p++) begin
                if (p_cs[p] && p_rd[p] && !p_wr[p]) begin
                    for (int d = 0; d < 2; d++)
                        q[d*2+p].push_back('{p_ovr[p] ? p_exp[p] : old[p],
                                             ecnt + lat[d*2+p]});
                end
            end
            if (p_cs[1] && p_wr[1])
                model[p_addr[1]] = merge(model[p_addr[1]], p_wd[1], p_be[1]);
            if (p_cs[0] && p_wr[0])
                model[p_addr[0]] = merge(model[p_addr[0]], p_wd[0], p_be[0]);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic clear_len(input string tag);
        int na = 0;
        int nb = 0;
        int n = 0;
        while ((busy_a === 1'b1 || busy_b === 1'b1) && n < 2000) begin
            if (busy_a === 1'b1) na++;
            if (busy_b === 1'b1) nb++;
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        assert (na == 1024 && nb == 1024) else begin
            errors++;
            $error("FAIL %s busy_cycles observed %0d/%0d expected 1024", tag, na, nb);
        end
        vectors++;
        assert (wt[0] === 1'b0 && wt[3] === 1'b0) else begin
            errors++;
            $error("FAIL %s wait_after_clear observed %b/%b expected 0", tag, wt[0], wt[3]);
        end
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    task automatic drain();
        repeat (6) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            assert (q[i].size() == 0) else begin
                errors++;
                $error("FAIL missing_valid[%0d] observed %0d pending expected 0", i, q[i].size());
            end
        end
    endtask

    initial begin
        idle();
        clken = 1'b1;
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            assert (vld[i] === 1'b0 && dat[i] === 32'h0 && wt[i] === 1'b1) else begin
                errors++;
                $error("FAIL reset[%0d] observed vld=%b data=%h wait=%b expected 0/0/1",
                       i, vld[i], dat[i], wt[i]);
            end
        end
        vectors++;
        assert (busy_a === 1'b1 && busy_b === 1'b1) else begin
            errors++;
            $error("FAIL reset_busy observed %b/%b expected 1", busy_a, busy_b);
        end
        reset_n = 1'b1;
        clear_len("clear");

        set_rd(0, 10'd0, 32'h0);    set_rd(1, 10'd1023, 32'h0); step();
        set_rd(0, 10'd511, 32'h0);  set_rd(1, 10'd0, 32'h0);    step();
        set_rd(0, 10'd1023, 32'h0); set_rd(1, 10'd511, 32'h0);  step();
        drain();

        set_wr(0, 10'd5, 32'hDEADBEEF, 4'b1111); step();
        set_wr(0, 10'd5, 32'h11223344, 4'b0101); step();
        set_rd(1, 10'd5, 32'hDE22BE44); step();
        drain();

        set_wr(0, 10'd7, 32'hAAAAAAAA, 4'b0011);
        set_wr(1, 10'd7, 32'hBBBBBBBB, 4'b0110); step();
        set_rd(0, 10'd7, 32'h00BBAAAA); step();
        drain();

        set_wr(0, 10'd3, 32'h9, 4'b1111); step();
        set_wr(0, 10'd3, 32'h5, 4'b1111);
        set_rd(1, 10'd3, 32'h9); step();
        set_rd(1, 10'd3, 32'h5); step();
        drain();

        set_rd(1, 10'd5, 32'hDE22BE44); step();
        set_rd(1, 10'd7, 32'h00BBAAAA); step();
        clken = 1'b0;
        repeat (3) step();
        clken = 1'b1;
        set_rd(1, 10'd3, 32'h5); step();
        set_rd(1, 10'd0, 32'h0); step();
        drain();

        for (int c = 0; c < 300; c++) begin
            clken = ($urandom_range(7) != 0);
            for (int p = 0; p < 2; p++) begin
                p_cs[p]   = ($urandom_range(3) != 0);
                p_rd[p]   = $urandom_range(1) == 1;
                p_wr[p]   = $urandom_range(1) == 1;
                p_addr[p] = 10'($urandom_range(15));
                p_be[p]   = 4'($urandom);
                p_wd[p]   = $urandom;
            end
            step();
        end
        clken = 1'b1;
        drain();

        for (int a = 0; a < 4; a++) begin
            set_wr(0, 10'(a * 341), 32'hC0DE0000 | 32'(a), 4'b1111);
            step();
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (300) begin @(posedge clk); #1; end
        vectors++;
        assert (busy_a === 1'b1 && busy_b === 1'b1) else begin
            errors++;
            $error("FAIL mid_clear_busy observed %b/%b expected 1", busy_a, busy_b);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_len("restart");
        for (int a = 0; a < 4; a++) begin
            set_rd(0, 10'(a * 341), 32'h0);
            set_rd(1, 10'(a * 341 + 1), 32'h0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
